// File: rtl/xmpl_loongson_ctrl.sv
// Command scheduler in front of a single xmpl_loongson core.
// Picks one requester round-robin, issues its command with a one-cycle start
// strobe, waits for the core's done bit (or a timeout) and hands the captured
// status back to the requester that owns the command.
module xmpl_loongson_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int CMD_W   = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*CMD_W-1:0]  req_cmd_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [DATA_W-1:0]         rsp_status_o,
  output logic                      rsp_timeout_o,
  output logic                      core_start_o,
  output logic [CMD_W-1:0]          core_cmd_o,
  output logic [DATA_W-1:0]         core_data_o,
  input  logic [DATA_W-1:0]         core_status_i,
  output logic                      busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);
  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] id_q;
  logic [TO_W-1:0] to_cnt;

  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic            accept;
  logic            core_done;
  logic            to_hit;
  logic            rsp_fire;

  assign core_done = core_status_i[0];
  assign to_hit    = (to_cnt == TO_LIMIT);
  assign rsp_fire  = (state == RESP) && rsp_ready_i;
  // Reset gating keeps every output low while reset is held, even if a
  // requester keeps its valid up.
  assign accept    = (state == IDLE) && grant_found && !reset_i;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // One-hot ready toward the winning requester, only while idle.
  always_comb begin
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready_o[k] = accept && (grant_id == ID_W'(k));
    end
  end

  // Next-state selection; done takes priority over the timeout limit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (core_done || to_hit) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration history: updated when the owner takes its response.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_grant <= LAST_INIT;
    end else if (rsp_fire) begin
      last_grant <= rsp_id_o;
    end
  end

  // Command latch: the core sees the winner's command from the strobe onward
  // and the values persist after the transaction completes.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      core_cmd_o  <= '0;
      core_data_o <= '0;
      id_q        <= '0;
    end else if (accept) begin
      core_cmd_o  <= req_cmd_i[grant_id*CMD_W +: CMD_W];
      core_data_o <= req_data_i[grant_id*DATA_W +: DATA_W];
      id_q        <= grant_id;
    end
  end

  // Wait-cycle counter: cleared on the strobe, advanced while waiting.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      to_cnt <= '0;
    end else if (state == ISSUE) begin
      to_cnt <= '0;
    end else if ((state == WAIT) && !core_done && !to_hit) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Response capture when leaving WAIT; fields hold until the next capture.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rsp_id_o      <= '0;
      rsp_status_o  <= '0;
      rsp_timeout_o <= 1'b0;
    end else if ((state == WAIT) && (core_done || to_hit)) begin
      rsp_id_o      <= id_q;
      rsp_status_o  <= core_status_i;
      rsp_timeout_o <= !core_done;
    end
  end

  assign core_start_o = (state == ISSUE);
  assign rsp_valid_o  = (state == RESP);
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_xmpl_loongson_ctrl.sv
// Directed bench for xmpl_loongson_ctrl with a short timeout (4 wait cycles).
module tb_xmpl_loongson_ctrl;

  localparam int NUM_REQ = 2;
  localparam int CMD_W   = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;
  localparam int ID_W    = 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*CMD_W-1:0]  req_cmd;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_status;
  logic                      rsp_timeout;
  logic                      core_start;
  logic [CMD_W-1:0]          core_cmd;
  logic [DATA_W-1:0]         core_data;
  logic [DATA_W-1:0]         core_status;
  logic                      busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  xmpl_loongson_ctrl #(
    .NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .DATA_W(DATA_W),
    .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_cmd_i(req_cmd), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_status_o(rsp_status), .rsp_timeout_o(rsp_timeout),
    .core_start_o(core_start), .core_cmd_o(core_cmd), .core_data_o(core_data),
    .core_status_i(core_status), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic e;
    rst = 1'b1; req_valid = '0; req_cmd = '0; req_data = '0;
    rsp_ready = 1'b0; core_status = '0;
    repeat (2) tick();
    chk("rst_ctrl", 64'({req_ready, rsp_valid, rsp_id, rsp_timeout, core_start, busy}), 64'd0);
    chk("rst_cmd", 64'(core_cmd), 64'd0);
    chk("rst_data", 64'(core_data), 64'd0);
    chk("rst_status", 64'(rsp_status), 64'd0);
    rst = 1'b0;
    tick();

    // Single request; done raised two cycles after the strobe.
    req_cmd[11:0] = 12'h0A5; req_data[31:0] = 32'hDEADBEEF; req_valid = 2'b01;
    #1;
    chk("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    chk("t1_start", 64'(core_start), 64'h1);
    chk("t1_cmd", 64'(core_cmd), 64'h0A5);
    chk("t1_data", 64'(core_data), 64'hDEADBEEF);
    chk("t1_busy_noready", 64'({busy, req_ready}), 64'h4);
    tick();
    chk("t1_start_once", 64'(core_start), 64'h0);
    tick();
    chk("t1_not_yet", 64'(rsp_valid), 64'h0);
    core_status = 32'h1;
    tick();
    chk("t1_rsp", 64'({rsp_valid, rsp_id, rsp_timeout}), 64'b100);
    chk("t1_status", 64'(rsp_status), 64'h1);
    core_status = '0; rsp_ready = 1'b1;
    tick();
    chk("t1_idle", 64'({rsp_valid, busy}), 64'h0);
    chk("t1_hold", 64'({rsp_id, rsp_status}), 64'h1);
    chk("t1_cmd_hold", 64'(core_cmd), 64'h0A5);

    // Fairness from reset: both requesters always valid, immediate done.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    req_cmd = {12'h222, 12'h111}; req_data = {32'hBBBB0002, 32'hAAAA0001};
    core_status = 32'h1; rsp_ready = 1'b1; req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      e = (i % 2) == 1;
      chk("rr_ready", 64'(req_ready), e ? 64'h2 : 64'h1);
      tick();
      chk("rr_start", 64'(core_start), 64'h1);
      chk("rr_cmd", 64'(core_cmd), e ? 64'h222 : 64'h111);
      tick(); tick();
      chk("rr_rsp", 64'({rsp_valid, rsp_id}), {62'd0, 1'b1, e});
      if (i == 3) req_valid = 2'b00;
      tick();
    end
    chk("rr_idle", 64'({busy, req_ready}), 64'h0);

    // Timeout: requester 1, core never done.
    core_status = 32'h12340000; rsp_ready = 1'b0; req_valid = 2'b10;
    #1;
    chk("to_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    tick();
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("to_latency", 64'(n), 64'd5);
    chk("to_rsp", 64'({rsp_valid, rsp_id, rsp_timeout}), 64'b111);
    chk("to_status", 64'(rsp_status), 64'h12340000);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // Done on the same cycle the counter reaches the limit.
    core_status = '0; req_valid = 2'b01;
    #1;
    chk("co_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    tick();
    repeat (4) tick();
    chk("co_pending", 64'(rsp_valid), 64'h0);
    core_status = 32'h5;
    tick();
    chk("co_rsp", 64'({rsp_valid, rsp_id, rsp_timeout}), 64'b100);
    chk("co_status", 64'(rsp_status), 64'h5);

    // Backpressure: response held, nothing else granted or started.
    req_valid = 2'b11; core_status = '0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 64'({rsp_valid, rsp_id, rsp_timeout, req_ready, core_start, busy}), 64'b1000001);
      chk("bp_status", 64'(rsp_status), 64'h5);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_next_grant", 64'(req_ready), 64'h2);
    tick();
    rsp_ready = 1'b0;
    chk("rm_cmd", 64'(core_cmd), 64'h222);
    tick();
    chk("rm_busy", 64'(busy), 64'h1);

    // Asynchronous reset in the middle of WAIT.
    rst = 1'b1;
    #1;
    chk("rm_ctrl", 64'({req_ready, rsp_valid, rsp_id, rsp_timeout, core_start, busy}), 64'd0);
    chk("rm_cmd0", 64'(core_cmd), 64'd0);
    chk("rm_data0", 64'(core_data), 64'd0);
    chk("rm_status0", 64'(rsp_status), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rm_first", 64'(req_ready), 64'h1);
    tick();
    chk("rm_start", 64'({core_start, core_cmd}), {51'd0, 1'b1, 12'h111});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xmpl_loongson_ctrl.md
Name: xmpl_loongson_ctrl

Overview:
Command scheduler that shares one xmpl_loongson core between NUM_REQ requesters. It arbitrates round-robin and issues one command at a time: a one-cycle start strobe plus a 12-bit command and a 32-bit operand. It then waits for the core's done flag or a timeout and returns the captured status to the winning requester. It sits between the requester fabric and the core instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
CMD_W, 12, command width driven to core b input
DATA_W, 32, operand/status width
TIMEOUT, 255, max WAIT cycles before abort (1..2^TO_W-1)
TO_W, 8, timeout counter width
ID_W, $clog2(NUM_REQ) (min 1), requester id width (derived localparam)

Ports:
clk_i  in  1  clock, all logic on rising edge
reset_i  in  1  asynchronous, active-high reset
req_valid_i  in  NUM_REQ  per-requester command valid
req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
req_cmd_i  in  NUM_REQ*CMD_W  packed commands, requester k at [k*CMD_W +: CMD_W]
req_data_i  in  NUM_REQ*DATA_W  packed operands, same packing
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accept
rsp_id_o  out  ID_W  requester id owning the response
rsp_status_o  out  DATA_W  status captured from core
rsp_timeout_o  out  1  1 = command aborted by timeout
core_start_o  out  1  start strobe to core a input
core_cmd_o  out  CMD_W  command to core b input
core_data_o  out  DATA_W  operand to core c input
core_status_i  in  DATA_W  core status; bit 0 = done
busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (async, immediate): state IDLE; every output 0; last_grant = NUM_REQ-1, so requester 0 has first priority; timeout counter 0. Reset mid-command aborts it silently: core_start_o drops at once and no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant g = first k with req_valid_i[k]=1, searching from (last_grant+1) mod NUM_REQ upward with wrap. req_ready_o[g]=1 combinationally in the same cycle; all other ready bits are 0. On the handshake, latch cmd/data/id and go to ISSUE. With no valid, stay in IDLE and drive all ready low.
- req_ready_o is 0 in every state except IDLE; at most one command is in flight.
- ISSUE: core_start_o=1 for exactly one cycle; counter cleared; go to WAIT.
- core_cmd_o and core_data_o are registered. They hold the latched values from ISSUE through RESP and keep their last value afterwards (0 only after reset).
- WAIT: each cycle, if core_status_i[0]=1, capture core_status_i into rsp_status_o, set rsp_timeout_o=0, go to RESP.
- Otherwise, if counter==TIMEOUT, capture core_status_i, set rsp_timeout_o=1, go to RESP.
- Otherwise increment the counter.
- If done and counter==TIMEOUT in the same cycle, done wins (timeout=0).
- The first WAIT cycle is the cycle after the strobe; done asserted during the ISSUE cycle is ignored.
- RESP: rsp_valid_o=1 with stable id/status/timeout until rsp_ready_i=1. On that cycle set last_grant=rsp_id_o, then clear rsp_valid_o next cycle and return to IDLE.
- rsp_id_o/status/timeout hold their values after the handshake.
- Latency (done on first WAIT cycle, rsp_ready_i held 1): accept at T, core_start_o at T+1, done sampled at T+2, rsp_valid_o at T+3, next accept at T+4 at the earliest.
- Timeout path: rsp_valid_o rises TIMEOUT+1 cycles after the first WAIT cycle.
- Requesters may change or drop req_valid_i at any time without a handshake; no state is kept for them.

Test Plan:
- Reset then single request: req0 valid, cmd=0x0A5, data=0xDEADBEEF; core raises status=0x00000001 two cycles after start -> core_start_o one pulse at T+1, core_cmd_o=0x0A5, core_data_o=0xDEADBEEF, rsp_valid_o with id=0, status=0x1, timeout=0.
- Round-robin fairness: both requesters valid continuously, core done immediately -> grants alternate 0,1,0,1 over 4 commands; never two consecutive grants to the same requester.
- Timeout with TIMEOUT=4: core never sets bit 0, status=0x12340000 -> rsp_valid_o 5 cycles after the first WAIT cycle, timeout=1, status=0x12340000.
- Done coincident with timeout count: done asserted when counter==TIMEOUT -> timeout=0.
- Response backpressure: rsp_ready_i low 10 cycles -> rsp fields stable, req_ready_o all 0, core_start_o stays 0, no new grant.
- Reset mid-WAIT: assert reset_i asynchronously -> all outputs 0 immediately; after release, req0 is granted first even if req1 was in flight.
